// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data memory controller.
// Access sizes, FSM states and the latency pipe bundle.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int MAX_LATENCY = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] word;
  } pipe_t;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle of the data memory.
// master drives requests, slave answers with in-order pulses.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for the data memory.
// Store enables/replication and load select plus extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // store: enable the addressed lanes, replicate data onto them
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    unique case (1'b1)
      st_size == SIZE_BYTE: begin
        st_be    = 4'b0001 << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      st_size == SIZE_HALF: begin
        st_be    = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      st_size == SIZE_WORD: st_be = 4'b1111;
      default:              st_be = 4'b0000;
    endcase
  end

  // load: pick the addressed lanes and sign/zero extend
  always_comb begin
    ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    unique case (1'b1)
      ld_size == SIZE_BYTE:
        ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      ld_size == SIZE_HALF:
        ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:
        ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: pipelined data memory with valid/ready requests.
// Byte-lane stores, extended loads, fixed-latency in-order responses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus,
  output logic   busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
  localparam state_t      RST_STATE =
    CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t      state;
  logic [AW-1:0] clr_ptr;
  logic [31:0] mem [DEPTH];

  pipe_t [READ_LATENCY-1:0] pipe;
  pipe_t       tail;

  logic [31:0] offset;
  logic        in_range;
  logic [1:0]  lane;
  logic [AW-1:0] idx;
  logic        err;
  logic        accept;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // base-relative decode and fault detection
  always_comb begin
    offset   = bus.req_addr - BASE_ADDR;
    in_range = (bus.req_addr >= BASE_ADDR)
             && ({1'b0, offset} < SPAN);
    lane     = offset[1:0];
    idx      = offset[AW+1:2];
    err      = !in_range;
    unique case (1'b1)
      bus.req_size == SIZE_BYTE: err = !in_range;
      bus.req_size == SIZE_HALF: err = err | lane[0];
      bus.req_size == SIZE_WORD: err = err | (lane != 2'b00);
      default:                   err = 1'b1;
    endcase
  end

  assign accept = bus.req_valid & bus.req_ready;
  assign tail   = pipe[READ_LATENCY-1];

  dmem_lane_align u_align (
    .st_size     (bus.req_size),
    .st_lane     (lane),
    .st_data     (bus.req_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_size     (tail.size),
    .ld_unsigned (tail.uns),
    .ld_lane     (tail.lane),
    .ld_word     (tail.word),
    .ld_data     (ld_data)
  );

  // clear walker FSM with registered ready/busy flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST_STATE;
      clr_ptr       <= '0;
      busy          <= CLEAR_ON_RESET;
      bus.req_ready <= 1'b0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          busy          <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

  // single write port: clear walker or committed store
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (accept && bus.req_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  // latency pipe: capture request and word at accept, then shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{
        valid: accept,
        err:   err,
        write: bus.req_write,
        size:  bus.req_size,
        uns:   bus.req_unsigned,
        lane:  lane,
        word:  mem[idx]
      };
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // registered response from the last pipe stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= tail.valid;
      bus.rsp_error <= tail.valid & tail.err;
      bus.rsp_rdata <= (tail.valid && !tail.err && !tail.write)
                     ? ld_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized bench against a byte-array memory model.
// Second instance covers long latency, offset base and reset in flight.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int          DEPTH  = 256;
  localparam int          LAT    = 2;
  localparam int          DEPTH4 = 16;
  localparam logic [31:0] BASE4  = 32'h0000_1000;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic reset4 = 1'b1;
  logic busy;
  logic busy4;

  dmem_if bus ();
  dmem_if bus4 ();

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mm [DEPTH*4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(
    .DEPTH(DEPTH), .BASE_ADDR(32'h0),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  dmem_ctrl #(
    .DEPTH(DEPTH4), .BASE_ADDR(BASE4),
    .READ_LATENCY(4), .CLEAR_ON_RESET(1'b0)
  ) u_dut4 (
    .clk(clk), .reset(reset4), .bus(bus4), .busy(busy4)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // reference: little-endian byte array, size = 1<<sz bytes
  function automatic exp_t model(bit wr, logic [1:0] sz, bit uns,
                                 logic [31:0] addr,
                                 logic [31:0] wd);
    exp_t        e;
    int          n;
    int          off;
    logic [31:0] v;
    e.due   = 0;
    e.rdata = '0;
    e.err   = 1'b0;
    n       = 1 << sz;
    if (sz == 2'b11 || addr >= 32'(DEPTH * 4)) begin
      e.err = 1'b1;
      return e;
    end
    off = int'(addr);
    if ((off % n) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) mm[off+i] = wd[8*i +: 8];
      return e;
    end
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mm[off+i];
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    e.rdata = v;
    return e;
  endfunction

  task automatic issue(bit wr, logic [1:0] sz, bit uns,
                       logic [31:0] addr, logic [31:0] wd,
                       output logic [31:0] exp_rd,
                       output logic exp_err);
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    check("ready_at_issue", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    e       = model(wr, sz, uns, addr, wd);
    e.due   = cyc + LAT;
    q.push_back(e);
    exp_rd  = e.rdata;
    exp_err = e.err;
  endtask

  task automatic idle(int n);
    bus.req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic one4(bit wr, logic [1:0] sz, bit uns,
                      logic [31:0] addr, logic [31:0] wd,
                      output int lat, output logic [31:0] rd,
                      output logic er);
    bus4.req_valid    = 1'b1;
    bus4.req_write    = wr;
    bus4.req_size     = sz;
    bus4.req_unsigned = uns;
    bus4.req_addr     = addr;
    bus4.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus4.req_valid = 1'b0;
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus4.rsp_valid && lat < 0) begin
        lat = k;
        rd  = bus4.rsp_rdata;
        er  = bus4.rsp_error;
      end
    end
  endtask

  // per-cycle compare of the main instance against the model queue
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.req_ready), 32'd1);
      check("busy", 32'(busy), 32'd0);
      if (q.size() > 0 && q[0].due == cyc) begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_rdata", bus.rsp_rdata, q[0].rdata);
        check("rsp_error", 32'(bus.rsp_error), 32'(q[0].err));
        void'(q.pop_front());
      end else begin
        check("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [1:0]  sz;
    logic [31:0] a;
    int          cnt;
    int          lat;

    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_size      = SIZE_WORD;
    bus.req_unsigned  = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus4.req_valid    = 1'b0;
    bus4.req_write    = 1'b0;
    bus4.req_size     = SIZE_WORD;
    bus4.req_unsigned = 1'b0;
    bus4.req_addr     = '0;
    bus4.req_wdata    = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_error", 32'(bus.rsp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    reset = 1'b0;
    cnt   = 0;
    while (busy && cnt < 400) begin
      check("clear_not_ready", 32'(bus.req_ready), 32'd0);
      cnt++;
      @(negedge clk);
    end
    check("clear_cycles", cnt, 32'd256);
    check("ready_after_clear", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;
    chk_en = 1'b1;

    issue(0, SIZE_WORD, 0, 32'h3FC, 0, r, e);
    idle(0);
    check("m_lw_3fc", r, 32'h0);

    issue(1, SIZE_WORD, 0, 32'h40, 32'hDEAD_BEEF, r, e);
    issue(0, SIZE_WORD, 0, 32'h40, 0, r, e);
    idle(1);
    check("m_lw_40", r, 32'hDEAD_BEEF);

    issue(1, SIZE_BYTE, 0, 32'h41, 32'h0000_00AA, r, e);
    issue(0, SIZE_BYTE, 0, 32'h41, 0, r, e);
    check("m_lb_41", r, 32'hFFFF_FFAA);
    issue(0, SIZE_BYTE, 1, 32'h41, 0, r, e);
    check("m_lbu_41", r, 32'h0000_00AA);
    issue(0, SIZE_WORD, 0, 32'h40, 0, r, e);
    check("m_lw_40b", r, 32'hDEAD_AAEF);
    issue(0, SIZE_HALF, 0, 32'h42, 0, r, e);
    check("m_lh_42", r, 32'hFFFF_DEAD);
    issue(0, SIZE_HALF, 1, 32'h42, 0, r, e);
    check("m_lhu_42", r, 32'h0000_DEAD);
    idle(3);

    issue(0, SIZE_WORD, 0, 32'h42, 0, r, e);
    check("m_err_lw42", 32'(e), 32'd1);
    issue(0, SIZE_HALF, 0, 32'h43, 0, r, e);
    check("m_err_lh43", 32'(e), 32'd1);
    issue(0, 2'b11, 0, 32'h0, 0, r, e);
    check("m_err_size", 32'(e), 32'd1);
    issue(1, SIZE_WORD, 0, 32'h400, 32'h1234_5678, r, e);
    check("m_err_range", 32'(e), 32'd1);
    issue(0, SIZE_WORD, 0, 32'h0, 0, r, e);
    check("m_lw_0", r, 32'h0);
    idle(2);

    issue(1, SIZE_WORD, 0, 32'h80, 32'h1122_3344, r, e);
    issue(0, SIZE_WORD, 0, 32'h80, 0, r, e);
    check("m_stream_first", r, 32'h1122_3344);
    issue(0, SIZE_WORD, 0, 32'h84, 0, r, e);
    issue(0, SIZE_WORD, 0, 32'h88, 0, r, e);
    issue(0, SIZE_WORD, 0, 32'h8C, 0, r, e);
    idle(LAT + 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sz = 2'b11;
      else sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, 63)) + 32'h100;
      else a = 32'($urandom_range(0, 32'h40F));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) begin
        a = a & ~((32'd1 << sz) - 32'd1);
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            a, $urandom, r, e);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(LAT + 3);
    check("queue_drained", q.size(), 32'd0);
    chk_en = 1'b0;

    @(negedge clk);
    check("r4_ready", 32'(bus4.req_ready), 32'd0);
    check("r4_busy", 32'(busy4), 32'd0);
    check("r4_valid", 32'(bus4.rsp_valid), 32'd0);
    reset4 = 1'b0;
    @(negedge clk);
    check("r4_ready_up", 32'(bus4.req_ready), 32'd1);
    check("r4_busy_low", 32'(busy4), 32'd0);

    one4(1, SIZE_WORD, 0, BASE4 + 32'h4, 32'hCAFE_F00D, lat, r, e);
    check("l4_sw_lat", lat, 32'd4);
    check("l4_sw_rdata", r, 32'h0);
    check("l4_sw_err", 32'(e), 32'd0);
    one4(0, SIZE_WORD, 0, BASE4 + 32'h4, 0, lat, r, e);
    check("l4_lw_lat", lat, 32'd4);
    check("l4_lw_rdata", r, 32'hCAFE_F00D);
    one4(0, SIZE_BYTE, 1, BASE4 + 32'h5, 0, lat, r, e);
    check("l4_lbu", r, 32'h0000_00F0);
    one4(0, SIZE_BYTE, 0, BASE4 + 32'h5, 0, lat, r, e);
    check("l4_lb", r, 32'hFFFF_FFF0);
    one4(0, SIZE_HALF, 0, BASE4 - 32'h2, 0, lat, r, e);
    check("l4_below_err", 32'(e), 32'd1);
    check("l4_below_rdata", r, 32'h0);
    one4(0, SIZE_WORD, 0, BASE4 + 32'h40, 0, lat, r, e);
    check("l4_above_err", 32'(e), 32'd1);

    bus4.req_valid = 1'b1;
    bus4.req_write = 1'b0;
    bus4.req_size  = SIZE_WORD;
    bus4.req_addr  = BASE4 + 32'h4;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus4.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("l4_first_pulse", 32'(bus4.rsp_valid), 32'd1);
    reset4 = 1'b1;
    #1;
    check("l4_async_drop", 32'(bus4.rsp_valid), 32'd0);
    check("l4_async_rdata", bus4.rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset4 = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus4.rsp_valid) cnt++;
    end
    check("l4_no_stale", cnt, 32'd0);
    one4(0, SIZE_WORD, 0, BASE4 + 32'h4, 0, lat, r, e);
    check("l4_retained_lat", lat, 32'd4);
    check("l4_retained", r, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data memory for the pipelined CPU generation.
- Adds over the fixed single-cycle memory:
  - valid/ready request handshake and configurable read latency, with in-order responses.
  - byte/halfword/word access with byte-lane stores and sign/zero-extended loads.
  - base-relative address decoding and misalignment/range error reporting.
  - a sequential clear-on-reset walker instead of clearing the whole array in one edge.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- READ_LATENCY, 1: cycles from accept edge to response; legal range 1..4.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = contents retained, no clear phase.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  block can accept this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load result; 0 for stores and errors
- rsp_error  output  1  qualifies rsp_valid: range, alignment or size fault
- busy  output  1  clear phase in progress

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency pipe flushed.
  - busy=1 and state CLEAR, clr_ptr=0 if CLEAR_ON_RESET=1.
  - Otherwise state IDLE with busy=0.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes 0 to word clr_ptr each cycle and increments it. After the word DEPTH-1 write, moves to IDLE; the clear lasts exactly DEPTH cycles.
  - IDLE: terminal until the next reset.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on a rising edge with req_valid && req_ready.
  - One request per cycle; no backpressure on responses.
- Decode:
  - offset = req_addr - BASE_ADDR (32-bit unsigned).
  - In range iff req_addr >= BASE_ADDR and offset < DEPTH*4.
  - Word index = offset[clog2(DEPTH)+1:2]; lane = offset[1:0].
- Error conditions: out of range; size 11; half with lane[0]=1; word with lane!=0.
  - An errored request performs no write. It still produces a response with rsp_error=1 and rsp_rdata=0.
- Stores:
  - Committed at the accept edge.
  - Byte: wdata[7:0] into lane.
  - Half: wdata[15:0] into lanes {lane[1],0}/{lane[1],1}.
  - Word: all lanes.
  - Other bytes unchanged.
- Loads:
  - Array word sampled at the accept edge.
  - Lane extraction and extension per req_size/req_unsigned are carried down the pipe.
- Response timing: every accepted request, load or store, yields exactly one rsp_valid pulse READ_LATENCY cycles after its accept edge. Responses are in order; back-to-back accepts give back-to-back pulses.
- Store followed by load:
  - A load accepted the cycle after a store to the same word returns the updated data.
  - No same-cycle read/write conflict is possible, since the memory is single-port.
- Reset mid-operation: in-flight responses are discarded; no response for a pre-reset request ever appears.
- Contents across reset:
  - CLEAR_ON_RESET=1: the clear restarts from word 0.
  - CLEAR_ON_RESET=0: contents retained.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - FSM state encoding ST_CLEAR/ST_IDLE.
  - the READ_LATENCY maximum constant.
- Sub-module dmem_lane_align: combinational lane select plus sign/zero extension for loads, and byte-enable plus lane-shifted data generation for stores. It is instantiated once in dmem_ctrl.

Test Plan:
- Clear phase (DEPTH=256): after reset deassert, busy=1 and req_ready=0 for exactly 256 cycles. Then lw 0x3FC gives rsp_rdata=0x00000000, rsp_error=0.
- Word store/load (READ_LATENCY=2): sw 0x40 <= 0xDEADBEEF, then lw 0x40. rsp_valid pulses 2 cycles after each accept, and the lw response is 0xDEADBEEF.
- Byte/half access: sb 0x41 <= 0xAA, then:
  - lb 0x41 -> 0xFFFFFFAA; lbu 0x41 -> 0x000000AA.
  - lw 0x40 -> 0xDEADAAEF.
  - lh 0x42 -> 0xFFFFDEAD; lhu 0x42 -> 0x0000DEAD.
- Faults: each of the following returns rsp_error=1 and rdata=0; afterwards lw 0x0 is unchanged.
  - lw 0x42
  - lh 0x43
  - size=11
  - sw 0x400 <= 0x12345678
- Streaming: sw 0x80 <= 0x11223344 immediately followed by 4 back-to-back lw 0x80/0x84/0x88/0x8C. Responses are 5 consecutive pulses in order, and the first load returns 0x11223344.
- Reset in flight (READ_LATENCY=4): assert reset with 3 loads pending. rsp_valid drops asynchronously and no stale pulse follows after the reset is released.
